// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: instruction-port and data-port request/acknowledge handshakes
interface mc_ctrl_if;
    logic inst_req;
    logic inst_ack;
    logic mem_req;
    logic mem_we;
    logic mem_ack;

    modport master (output inst_req, mem_req, mem_we, input inst_ack, mem_ack);
    modport slave  (input inst_req, mem_req, mem_we, output inst_ack, mem_ack);
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle IF/ID/EX/MEM/WB control FSM for the RV32I core
module mc_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mc_ctrl_if.master            bus,
    input  logic [6:0]           opcode,
    input  logic                 br_taken,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 rf_we,
    output logic [1:0]           wb_sel,
    output logic                 trap,
    output logic [INSTRET_W-1:0] instret
);
    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_TRAP} state_t;
    typedef enum logic [2:0] {C_NONE, C_ALU, C_JAL, C_JALR, C_BR, C_LD, C_ST, C_ILL} cls_t;

    state_t state;
    cls_t   op_class;
    cls_t   dec_class;
    logic   retire;

    // classify the opcode currently held in IR
    always_comb begin
        dec_class = C_ILL;
        case (opcode)
            7'b0110111, 7'b0010111, 7'b0110011, 7'b0010011: dec_class = C_ALU;
            7'b1101111: dec_class = C_JAL;
            7'b1100111: dec_class = C_JALR;
            7'b1100011: dec_class = C_BR;
            7'b0000011: dec_class = C_LD;
            7'b0100011: dec_class = C_ST;
            default:    dec_class = C_ILL;
        endcase
    end

    // the fetch request is gated by rst_n so it drops the moment reset asserts
    assign bus.inst_req = rst_n && state == S_IF;
    assign bus.mem_req  = state == S_MEM;
    assign bus.mem_we   = state == S_MEM && op_class == C_ST;
    assign ir_we        = rst_n && state == S_IF && bus.inst_ack;
    assign retire       = (state == S_EX && op_class == C_BR) ||
                          (state == S_MEM && op_class == C_ST && bus.mem_ack) ||
                          state == S_WB;
    assign pc_we        = retire;
    assign rf_we        = state == S_WB;
    assign trap         = state == S_TRAP;

    // PC source and writeback source selection
    always_comb begin
        pc_src = ((state == S_EX && op_class == C_BR && br_taken) ||
                  (state == S_WB && op_class == C_JAL)) ? 2'd1 :
                 (state == S_WB && op_class == C_JALR) ? 2'd2 : 2'd0;
        wb_sel = state != S_WB ? 2'd0 :
                 op_class == C_LD ? 2'd1 :
                 (op_class == C_JAL || op_class == C_JALR) ? 2'd2 : 2'd0;
    end

    // state sequencing, op_class latch and retired-instruction count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IF;
            op_class <= C_NONE;
            instret  <= '0;
        end else begin
            case (state)
                S_IF:  if (bus.inst_ack) state <= S_ID;
                S_ID: begin
                    op_class <= dec_class;
                    state    <= dec_class == C_ILL ? S_TRAP : S_EX;
                end
                S_EX:  state <= op_class == C_BR ? S_IF :
                                (op_class == C_LD || op_class == C_ST) ? S_MEM : S_WB;
                S_MEM: if (bus.mem_ack) state <= op_class == C_LD ? S_WB : S_IF;
                S_WB:  state <= S_IF;
                S_TRAP: state <= S_TRAP;
                default: state <= S_IF;
            endcase
            if (retire) instret <= instret + INSTRET_W'(1);
        end
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: table-driven cycle-by-cycle check of the multi-cycle control FSM
module tb_mc_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        br_taken;
    logic        ir_we, pc_we, rf_we, trap;
    logic [1:0]  pc_src, wb_sel;
    logic [31:0] instret;
    logic        ir_we2, pc_we2, rf_we2, trap2;
    logic [1:0]  pc_src2, wb_sel2;
    logic [1:0]  instret2;
    int          total = 0;
    int          bad = 0;

    mc_ctrl_if bus ();
    mc_ctrl_if bus2 ();

    assign bus2.inst_ack = bus.inst_ack;
    assign bus2.mem_ack  = bus.mem_ack;

    mc_ctrl #(.INSTRET_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .opcode(opcode), .br_taken(br_taken),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we),
        .wb_sel(wb_sel), .trap(trap), .instret(instret)
    );

    // narrow counter copy: same stimulus, exercises the wrap from all-ones to zero
    mc_ctrl #(.INSTRET_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2), .opcode(opcode), .br_taken(br_taken),
        .ir_we(ir_we2), .pc_we(pc_we2), .pc_src(pc_src2), .rf_we(rf_we2),
        .wb_sel(wb_sel2), .trap(trap2), .instret(instret2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic        br;
        logic        ia;
        logic        ma;
        logic [10:0] exp;
        logic [31:0] cnt;
    } vec_t;

    // {inst_req, mem_req, mem_we, ir_we, pc_we, pc_src, rf_we, wb_sel, trap}
    localparam logic [10:0] IDLE   = 11'b0_0_0_0_0_00_0_00_0;
    localparam logic [10:0] IFW    = 11'b1_0_0_0_0_00_0_00_0;
    localparam logic [10:0] IFA    = 11'b1_0_0_1_0_00_0_00_0;
    localparam logic [10:0] WB_ALU = 11'b0_0_0_0_1_00_1_00_0;
    localparam logic [10:0] BR_T   = 11'b0_0_0_0_1_01_0_00_0;
    localparam logic [10:0] BR_N   = 11'b0_0_0_0_1_00_0_00_0;
    localparam logic [10:0] MEM_LD = 11'b0_1_0_0_0_00_0_00_0;
    localparam logic [10:0] WB_LD  = 11'b0_0_0_0_1_00_1_01_0;
    localparam logic [10:0] WB_JR  = 11'b0_0_0_0_1_10_1_10_0;
    localparam logic [10:0] MEM_ST = 11'b0_1_1_0_1_00_0_00_0;
    localparam logic [10:0] WB_JAL = 11'b0_0_0_0_1_01_1_10_0;
    localparam logic [10:0] TRAPV  = 11'b0_0_0_0_0_00_0_00_1;

    localparam logic [6:0] ADDI = 7'b0010011, BEQ = 7'b1100011, LW = 7'b0000011;
    localparam logic [6:0] JALR = 7'b1100111, SW = 7'b0100011, JAL = 7'b1101111;
    localparam logic [6:0] ILL = 7'b1111111;

    vec_t vecs[$];

    function automatic logic [10:0] outs();
        return {bus.inst_req, bus.mem_req, bus.mem_we, ir_we, pc_we, pc_src,
                rf_we, wb_sel, trap};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic [6:0] op, input logic br, input logic ia, input logic ma,
                       input logic [10:0] exp, input logic [31:0] cnt);
        vecs.push_back('{op, br, ia, ma, exp, cnt});
    endtask

    initial begin
        // ADDI, zero-wait
        add(ADDI, 0, 1, 0, IFA, 0); add(ADDI, 0, 0, 0, IDLE, 0);
        add(ADDI, 0, 0, 0, IDLE, 0); add(ADDI, 0, 0, 0, WB_ALU, 0);
        // BEQ taken (stray mem_ack in ID), then BEQ not taken
        add(BEQ, 1, 1, 0, IFA, 1); add(BEQ, 1, 0, 1, IDLE, 1); add(BEQ, 1, 0, 0, BR_T, 1);
        add(BEQ, 0, 1, 0, IFA, 2); add(BEQ, 0, 0, 0, IDLE, 2); add(BEQ, 0, 0, 0, BR_N, 2);
        // LW, mem_ack after 3 wait cycles, stray inst_ack during MEM
        add(LW, 0, 1, 0, IFA, 3); add(LW, 0, 0, 0, IDLE, 3); add(LW, 0, 0, 0, IDLE, 3);
        add(LW, 0, 1, 0, MEM_LD, 3); add(LW, 0, 0, 0, MEM_LD, 3);
        add(LW, 0, 0, 0, MEM_LD, 3); add(LW, 0, 0, 1, MEM_LD, 3);
        add(LW, 0, 0, 0, WB_LD, 3);
        // JALR
        add(JALR, 0, 1, 0, IFA, 4); add(JALR, 0, 0, 0, IDLE, 4);
        add(JALR, 0, 0, 0, IDLE, 4); add(JALR, 0, 0, 0, WB_JR, 4);
        // SW, zero-wait data port
        add(SW, 0, 1, 0, IFA, 5); add(SW, 0, 0, 0, IDLE, 5);
        add(SW, 0, 0, 0, IDLE, 5); add(SW, 0, 0, 1, MEM_ST, 5);
        // JAL with one fetch wait state
        add(JAL, 0, 0, 0, IFW, 6); add(JAL, 0, 1, 0, IFA, 6); add(JAL, 0, 0, 0, IDLE, 6);
        add(JAL, 0, 0, 0, IDLE, 6); add(JAL, 0, 0, 0, WB_JAL, 6);
        // illegal opcode: fetch and decode
        add(ILL, 0, 1, 0, IFA, 7); add(ILL, 0, 0, 0, IDLE, 7);

        rst_n = 1'b0; opcode = ADDI; br_taken = 1'b0;
        bus.inst_ack = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(IDLE));
        chk("reset_instret", instret, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("if_req_after_release", 32'(outs()), 32'(IFW));
        #2 rst_n = 1'b0;
        #1 chk("async_req_drop", 32'(bus.inst_req), 0);
        chk("async_trap", 32'(trap), 0);
        chk("async_instret", instret, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op; br_taken = vecs[i].br;
            bus.inst_ack = vecs[i].ia; bus.mem_ack = vecs[i].ma;
            @(negedge clk);
            chk($sformatf("outs[%0d]", i), 32'(outs()), 32'(vecs[i].exp));
            chk($sformatf("instret[%0d]", i), instret, vecs[i].cnt);
            chk($sformatf("instret_w2[%0d]", i), 32'(instret2), 32'(vecs[i].cnt[1:0]));
            @(posedge clk); #1;
        end

        for (int i = 0; i < 22; i++) begin
            bus.inst_ack = i[0]; bus.mem_ack = 1'b1; opcode = ADDI;
            @(negedge clk);
            chk($sformatf("trap_outs[%0d]", i), 32'(outs()), 32'(TRAPV));
            chk($sformatf("trap_instret[%0d]", i), instret, 7);
            @(posedge clk); #1;
        end

        bus.inst_ack = 1'b0; bus.mem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk("trap_cleared", 32'(trap), 0);
        chk("instret_cleared", instret, 0);
        chk("instret_w2_cleared", 32'(instret2), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("if_after_trap_reset", 32'(outs()), 32'(IFW));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
